wreg_uart_reporter: RTL and testbench
=====================================

// Module: wreg_uart_reporter
// PURPOSE
//  Downstream consumer of the FRANK6000 CPU outputs (WREG, loop flag).
//  Reports WREG to the host over UART as ASCII: two uppercase hex chars + CR + LF.
//  Sends one frame on a loop-flag rising edge, and optionally on any WREG change.
//  Sits beside the 7-seg display path; the host gets a log of results.
// PARAMETERS
//  CLKS_PER_BIT    217  clocks per UART bit (25 MHz / 115200); legal range >= 4
//  SEND_ON_CHANGE  1    1: a WREG value change also triggers a frame; 0: loop-flag edge only
// PORTS
//  i_clk        in   1  master clock
//  i_rst_n      in   1  reset, asynchronous, active-low
//  i_enable     in   1  reporting enable (tie to CPU ON); triggers are ignored while low
//  i_wreg       in   8  CPU working register
//  i_loopf      in   1  CPU loop/finish flag (level)
//  o_tx_serial  out  1  UART TX line, 8N1, LSB first, idle high
//  o_busy       out  1  high from the first start bit to the end of the last stop bit
//  o_done       out  1  one-cycle pulse after the LF stop bit completes
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): o_tx_serial=1, o_busy=0, o_done=0.
//    FSM goes to IDLE; pending flag, byte index, bit and baud counters are cleared.
//    Edge/change history registers take their current input values on the first clock after release.
//    So no frame is sent for the value present at reset release.
//  - Trigger in cycle k, evaluated only when i_enable=1:
//      (i_loopf=1 and loopf_prev=0), or
//      (SEND_ON_CHANGE=1 and i_wreg != wreg_prev).
//    The prev registers update every cycle, regardless of i_enable.
//  - Trigger in IDLE: snapshot i_wreg into the frame register at cycle k.
//    o_busy=1 and o_tx_serial=0 (start bit) from cycle k+1.
//  - Trigger while busy: set a single-deep pending flag; further triggers merge into it.
//    At the end of the frame, if pending is set: clear it and re-snapshot the current i_wreg.
//    The next start bit then begins on the next cycle; o_busy stays high between frames.
//    o_done still pulses once per completed frame.
//  - Frame bytes in order: hex(wreg[7:4]), hex(wreg[3:0]), 8'h0D, 8'h0A.
//    hex(n) = 8'h30+n for n<=9; 8'h37+n for n>=10 (uppercase 'A'..'F').
//  - FSM: IDLE -> START -> DATA -> STOP.
//    STOP -> START when byte index < 3 (increment index).
//    STOP -> START when byte index = 3 and pending is set (index=0, re-snapshot).
//    STOP -> IDLE otherwise.
//  - Each state bit lasts exactly CLKS_PER_BIT cycles.
//    Baud counter counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT).
//    Bit counter 0..7 in DATA. Frame = 40*CLKS_PER_BIT cycles; no idle gap between bytes.
//  - o_done asserts in the first cycle after the LF stop bit ends, whether the FSM returns to IDLE or restarts.
//  - i_enable falling mid-frame: the current frame completes; pending is cleared.
//  - Triggers while i_enable=0 are dropped, not queued.
//  - Reset mid-frame: line returns high immediately; no partial byte resumes after release.
//  - Simultaneous loopf edge and WREG change in one cycle count as a single trigger.
// TESTING (bench uses CLKS_PER_BIT=4 unless noted)
//  1. en=1, wreg 00->3A -> line decodes 0x33,0x41,0x0D,0x0A.
//     o_busy high for 160 cycles; o_done pulses once at cycle k+161.
//  2. CLKS_PER_BIT=217, wreg 00->FF -> bytes 0x46,0x46,0x0D,0x0A; each bit 217 cycles; frame 8680 cycles.
//  3. Mid-frame wreg 3A->12->C5 -> exactly one extra back-to-back frame with 0x43,0x35,0x0D,0x0A.
//     o_busy stays high; o_done pulses twice.
//  4. SEND_ON_CHANGE=0: wreg changes -> line stays high.
//     Then loopf 0->1 with wreg=07 -> frame 0x30,0x37,0x0D,0x0A.
//     loopf held high -> no further frames.
//  5. en=0, wreg changes and loopf edge -> no frame.
//     en 0->1 with wreg stable -> still no frame.
//  6. i_rst_n low during the second data byte -> o_tx_serial=1 and o_busy=0 asynchronously.
//     After release with stable inputs -> line stays idle.

Source files
------------

// File: rtl/wreg_uart_reporter.sv
// Reports the CPU working register over an 8N1 UART as two uppercase hex chars + CR + LF.
// A frame is triggered by a loop-flag rising edge or (optionally) a WREG change; one extra frame may queue.
module wreg_uart_reporter #(
    parameter int CLKS_PER_BIT   = 217,
    parameter bit SEND_ON_CHANGE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [7:0] i_wreg,
    input  logic       i_loopf,
    output logic       o_tx_serial,
    output logic       o_busy,
    output logic       o_done
);

    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    frame_q, frame_d;
    logic          pending_q, pending_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          loopf_prev_q;
    logic [7:0]    wreg_prev_q;
    logic          primed_q;

    logic          trigger;
    logic          baud_end;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // primed_q keeps the first post-reset cycle from seeing stale history as an edge/change.
    assign trigger = i_enable && primed_q &&
                     ((i_loopf && !loopf_prev_q) ||
                      (SEND_ON_CHANGE && (i_wreg != wreg_prev_q)));

    assign baud_end = (baud_q == BAUD_MAX);

    always_comb begin
        case (idx_q)
            2'd0:    cur_byte = hex_char(frame_q[7:4]);
            2'd1:    cur_byte = hex_char(frame_q[3:0]);
            2'd2:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE && trigger) begin
            pending_d = 1'b1;
        end
        if (!i_enable) begin
            pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    frame_d = i_wreg;
                    idx_d   = 2'd0;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        done_d = 1'b1;
                        // A trigger landing on the very last stop cycle still merges into the queued frame.
                        if (pending_d) begin
                            pending_d = 1'b0;
                            frame_d   = i_wreg;
                            idx_d     = 2'd0;
                            state_d   = S_START;
                            tx_d      = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            baud_q       <= '0;
            bit_q        <= 3'd0;
            idx_q        <= 2'd0;
            frame_q      <= 8'h00;
            pending_q    <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            loopf_prev_q <= 1'b0;
            wreg_prev_q  <= 8'h00;
            primed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            pending_q    <= pending_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            loopf_prev_q <= i_loopf;
            wreg_prev_q  <= i_wreg;
            primed_q     <= 1'b1;
        end
    end

    assign o_tx_serial = tx_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_wreg_uart_reporter.sv
// Bench for wreg_uart_reporter: three instances (fast, real baud, loop-flag-only) with a UART
// decoder per line feeding byte queues that are checked against hand-computed expected bytes.
module tb_wreg_uart_reporter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b0, en_a = 1'b1, loopf_a = 1'b0;
    logic [7:0] wreg_a = 8'h00;
    logic       tx_a, busy_a, done_a;

    logic       rst_b = 1'b0, en_b = 1'b1, loopf_b = 1'b0;
    logic [7:0] wreg_b = 8'h00;
    logic       tx_b, busy_b, done_b;

    logic       rst_c = 1'b0, en_c = 1'b1, loopf_c = 1'b0;
    logic [7:0] wreg_c = 8'h00;
    logic       tx_c, busy_c, done_c;

    wreg_uart_reporter #(.CLKS_PER_BIT(4), .SEND_ON_CHANGE(1'b1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_a), .i_enable(en_a), .i_wreg(wreg_a), .i_loopf(loopf_a),
        .o_tx_serial(tx_a), .o_busy(busy_a), .o_done(done_a));

    wreg_uart_reporter #(.CLKS_PER_BIT(217), .SEND_ON_CHANGE(1'b1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_b), .i_enable(en_b), .i_wreg(wreg_b), .i_loopf(loopf_b),
        .o_tx_serial(tx_b), .o_busy(busy_b), .o_done(done_b));

    wreg_uart_reporter #(.CLKS_PER_BIT(4), .SEND_ON_CHANGE(1'b0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_c), .i_enable(en_c), .i_wreg(wreg_c), .i_loopf(loopf_c),
        .o_tx_serial(tx_c), .o_busy(busy_c), .o_done(done_c));

    int tests = 0;
    int fails = 0;
    int frame_err = 0;
    int done_cnt_a = 0, done_cnt_c = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q_a[$], rx_q_b[$], rx_q_c[$];

    always @(negedge clk) begin
        if (done_a) done_cnt_a++;
        if (done_c) done_cnt_c++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic tx_of(input int inst);
        return (inst == 0) ? tx_a : (inst == 1) ? tx_b : tx_c;
    endfunction

    function automatic logic rst_of(input int inst);
        return (inst == 0) ? rst_a : (inst == 1) ? rst_b : rst_c;
    endfunction

    function automatic void rx_push(input int inst, input logic [7:0] b);
        if (inst == 0) rx_q_a.push_back(b);
        else if (inst == 1) rx_q_b.push_back(b);
        else rx_q_c.push_back(b);
    endfunction

    function automatic int rx_size(input int inst);
        return (inst == 0) ? rx_q_a.size() : (inst == 1) ? rx_q_b.size() : rx_q_c.size();
    endfunction

    function automatic logic [7:0] rx_pop(input int inst);
        if (inst == 0) return rx_q_a.pop_front();
        if (inst == 1) return rx_q_b.pop_front();
        return rx_q_c.pop_front();
    endfunction

    // Bytes interrupted by reset are discarded rather than queued.
    task automatic monitor(input int inst, input int cpb);
        logic [7:0] b;
        bit bad;
        forever begin
            @(negedge clk);
            if (rst_of(inst) && tx_of(inst) == 1'b0) begin
                bad = 1'b0;
                for (int i = 0; i < cpb / 2; i++) begin
                    @(negedge clk);
                    if (!rst_of(inst)) bad = 1'b1;
                end
                if (!bad && tx_of(inst) != 1'b0) frame_err++;
                for (int k = 0; k < 8; k++) begin
                    for (int i = 0; i < cpb; i++) begin
                        @(negedge clk);
                        if (!rst_of(inst)) bad = 1'b1;
                    end
                    b[k] = tx_of(inst);
                end
                for (int i = 0; i < cpb; i++) begin
                    @(negedge clk);
                    if (!rst_of(inst)) bad = 1'b1;
                end
                if (!bad) begin
                    if (tx_of(inst) != 1'b1) frame_err++;
                    rx_push(inst, b);
                end
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 217);
    initial monitor(2, 4);

    task automatic push_frame(input logic [7:0] hi, input logic [7:0] lo);
        exp_q.push_back(hi);
        exp_q.push_back(lo);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_rx(input int inst, input string name);
        logic [7:0] e;
        logic [7:0] a;
        int n;
        n = rx_size(inst);
        chk({name, " byte count"}, n, exp_q.size());
        if (n == exp_q.size()) begin
            for (int i = 0; i < n; i++) begin
                e = exp_q.pop_front();
                a = rx_pop(inst);
                chk($sformatf("%s byte %0d", name, i), a, e);
            end
        end
        exp_q.delete();
        while (rx_size(inst) > 0) a = rx_pop(inst);
    endtask

    typedef struct {
        logic [7:0] wreg;
        logic       loopf;
        logic       en;
        bit         frame;
        logic [7:0] hi;
        logic [7:0] lo;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int busy_cnt, first_busy, done_at, falls, d0;
        logic prev_busy;

        tbl[0]  = '{8'h09, 1'b0, 1'b1, 1'b1, 8'h30, 8'h39};
        tbl[1]  = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'h46, 8'h30};
        tbl[2]  = '{8'h5B, 1'b0, 1'b1, 1'b1, 8'h35, 8'h42};
        tbl[3]  = '{8'h5B, 1'b1, 1'b1, 1'b1, 8'h35, 8'h42};
        tbl[4]  = '{8'h5B, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[5]  = '{8'hC7, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{8'hC7, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{8'hC7, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[8]  = '{8'hE4, 1'b1, 1'b1, 1'b1, 8'h45, 8'h34};
        tbl[9]  = '{8'hE4, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
        tbl[10] = '{8'h6D, 1'b1, 1'b1, 1'b1, 8'h36, 8'h44};

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("reset tx", tx_a, 1'b1);
        chk("reset busy", busy_a, 1'b0);
        chk("reset done", done_a, 1'b0);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        busy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_a) busy_cnt++;
        end
        chk("no frame at release", busy_cnt, 0);

        // Single frame 00->3A with exact busy/done timing
        @(posedge clk); #1;
        wreg_a = 8'h3A;
        busy_cnt = 0; first_busy = -1; done_at = -1; d0 = done_cnt_a;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy_a) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = c;
            end
            if (done_a && done_at < 0) done_at = c;
        end
        chk("t1 busy first cycle", first_busy, 1);
        chk("t1 busy length", busy_cnt, 160);
        chk("t1 done cycle", done_at, 161);
        chk("t1 done pulses", done_cnt_a - d0, 1);
        push_frame(8'h33, 8'h41);
        check_rx(0, "t1");

        // Table-driven single-trigger vectors
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            wreg_a = tbl[i].wreg;
            loopf_a = tbl[i].loopf;
            en_a = tbl[i].en;
            d0 = done_cnt_a;
            repeat (200) @(negedge clk);
            chk($sformatf("vec%0d busy idle", i), busy_a, 1'b0);
            chk($sformatf("vec%0d done pulses", i), done_cnt_a - d0, tbl[i].frame ? 1 : 0);
            if (tbl[i].frame) push_frame(tbl[i].hi, tbl[i].lo);
            check_rx(0, $sformatf("vec%0d", i));
        end

        // Mid-frame changes 3A->12->C5 merge into one back-to-back frame
        @(posedge clk); #1;
        wreg_a = 8'h3A;
        busy_cnt = 0; falls = 0; prev_busy = 1'b0; d0 = done_cnt_a;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (c == 40) wreg_a = 8'h12;
            if (c == 80) wreg_a = 8'hC5;
            if (busy_a) busy_cnt++;
            if (prev_busy && !busy_a) falls++;
            prev_busy = busy_a;
        end
        chk("t3 busy length", busy_cnt, 320);
        chk("t3 busy falls", falls, 1);
        chk("t3 done pulses", done_cnt_a - d0, 2);
        push_frame(8'h33, 8'h41);
        push_frame(8'h43, 8'h35);
        check_rx(0, "t3");

        // Enable dropped mid-frame clears the pending frame
        @(posedge clk); #1;
        wreg_a = 8'h81;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (c == 20) wreg_a = 8'h82;
            if (c == 30) en_a = 1'b0;
        end
        @(posedge clk); #1;
        en_a = 1'b1;
        d0 = done_cnt_a;
        repeat (200) @(negedge clk);
        chk("en drop busy idle", busy_a, 1'b0);
        chk("en drop no extra done", done_cnt_a - d0, 0);
        push_frame(8'h38, 8'h31);
        check_rx(0, "en drop");

        // Reset during the second data byte
        @(posedge clk); #1;
        wreg_a = 8'h9E;
        repeat (51) @(negedge clk);
        chk("t6 line low before reset", tx_a, 1'b0);
        rst_a = 1'b0;
        #1;
        chk("t6 async tx", tx_a, 1'b1);
        chk("t6 async busy", busy_a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1;
        busy_cnt = 0; d0 = done_cnt_a;
        repeat (300) begin
            @(negedge clk);
            if (busy_a || !tx_a) busy_cnt++;
        end
        chk("t6 idle after release", busy_cnt, 0);
        chk("t6 no done", done_cnt_a - d0, 0);
        exp_q.push_back(8'h39);
        check_rx(0, "t6");

        // Real baud rate: 00->FF
        @(posedge clk); #1;
        wreg_b = 8'hFF;
        busy_cnt = 0; done_at = -1;
        for (int c = 0; c < 9000; c++) begin
            @(negedge clk);
            if (busy_b) busy_cnt++;
            if (done_b && done_at < 0) done_at = c;
        end
        chk("t2 busy length", busy_cnt, 8680);
        chk("t2 done cycle", done_at, 8681);
        push_frame(8'h46, 8'h46);
        check_rx(1, "t2");

        // Loop-flag-only instance
        busy_cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 10) wreg_c = 8'h11;
            if (c == 60) wreg_c = 8'h22;
            if (c == 110) wreg_c = 8'h07;
            if (busy_c || !tx_c) busy_cnt++;
        end
        chk("t4 change ignored", busy_cnt, 0);
        @(posedge clk); #1;
        loopf_c = 1'b1;
        d0 = done_cnt_c;
        repeat (200) @(negedge clk);
        chk("t4 done pulses", done_cnt_c - d0, 1);
        push_frame(8'h30, 8'h37);
        check_rx(2, "t4");
        busy_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 50) wreg_c = 8'h08;
            if (busy_c || !tx_c) busy_cnt++;
        end
        chk("t4 held loopf silent", busy_cnt, 0);
        check_rx(2, "t4 held");

        chk("uart framing errors", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
